cvrt_bin2gry_arb: RTL

- Round-robin arbiter that shares one cvrt_bin2gry converter instance between REQ_NUM requesters.
- Each requester offers a binary word over a valid/ready handshake. The arbiter grants one requester per cycle, passes its word through the shared converter, and registers the Gray result with the granted index into a single-entry output slot. The slot drains over a valid/ready handshake.
- Sits between pointer/counter producers (for example FIFO pointer logic) and consumers of Gray-coded values, so one converter serves several sources.

---
 rtl/cvrt_bin2gry_arb.sv | 107 ++++++++++
 1 files changed

// File: rtl/cvrt_bin2gry_arb.sv
// Round-robin arbiter sharing one binary-to-Gray converter between REQ_NUM requesters.
// The winning word is converted and registered with its requester index into a one-entry output slot.

module cvrt_bin2gry #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_bin,
  output logic [DATA_WIDTH-1:0] o_gry
);
  assign o_gry = i_bin ^ (i_bin >> 1);
endmodule

module cvrt_bin2gry_arb #(
  parameter int DATA_WIDTH = 4,
  parameter int REQ_NUM    = 2,
  localparam int IDX_WIDTH = $clog2(REQ_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_bin,
  output logic [REQ_NUM-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [DATA_WIDTH-1:0]         o_rsp_gry,
  output logic [IDX_WIDTH-1:0]          o_rsp_idx,
  output logic                          o_busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // producers hold valid and data stable until then, and ready never depends on a later cycle.

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_gry_q, rsp_gry_d;
  logic [IDX_WIDTH-1:0]  rsp_idx_q, rsp_idx_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  accept;
  logic                  found;
  logic                  grant;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] conv_bin;
  logic [DATA_WIDTH-1:0] conv_gry;

  assign accept = !rsp_valid_q || i_rsp_ready;

  // Search upward from the pointer with wrap; works for non-power-of-two REQ_NUM.
  always_comb begin : search
    int k;
    k         = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      k = int'(ptr_q) + i;
      if (k >= REQ_NUM) k = k - REQ_NUM;
      if (!found && i_req_valid[k]) begin
        found     = 1'b1;
        grant_idx = IDX_WIDTH'(k);
      end
    end
  end

  assign grant       = accept && found && !i_rst;
  assign o_req_ready = grant ? (REQ_NUM'(1) << grant_idx) : '0;

  assign conv_bin = i_req_bin[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  cvrt_bin2gry #(.DATA_WIDTH(DATA_WIDTH)) u_conv (
    .i_bin (conv_bin),
    .o_gry (conv_gry)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_gry_d   = rsp_gry_q;
    rsp_idx_d   = rsp_idx_q;
    ptr_d       = ptr_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_gry_d   = conv_gry;
      rsp_idx_d   = grant_idx;
      ptr_d       = (grant_idx == IDX_WIDTH'(REQ_NUM-1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_gry_q   <= '0;
      rsp_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_gry_q   <= rsp_gry_d;
      rsp_idx_q   <= rsp_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_gry   = rsp_gry_q;
  assign o_rsp_idx   = rsp_idx_q;
  assign o_busy      = !i_rst && (rsp_valid_q || (|i_req_valid));

endmodule
